// File: rtl/pow_seq_p.sv
// Sequential integer power unit: out = inx ** inn by square-and-multiply.
// Overflow is tracked as a sticky flag and the result wraps or saturates per SAT.
module pow_seq_p #(
    parameter int WIDTH = 16,
    parameter int EXPW  = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] inx,
    input  logic [EXPW-1:0]  inn,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [EXPW-1:0]    n_q, n_d;
    logic               ovfs_q, ovfs_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0] prod;

    // One shared multiplier: odd steps use acc*x, even steps use x*x.
    always_comb begin
        mul_a = n_q[0] ? acc_q : x_q;
        prod  = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, x_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            ovfs_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            ovfs_q  <= ovfs_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        n_d     = n_q;
        ovfs_d  = ovfs_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = inx;
                    n_d     = inn;
                    acc_d   = {{(WIDTH-1){1'b0}}, 1'b1};
                    ovfs_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    out_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end else if (n_q == '0) begin
                    out_d   = (SAT && ovfs_q) ? '1 : acc_q;
                    ovf_d   = ovfs_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ovfs_d = ovfs_q | (|prod[2*WIDTH-1:WIDTH]);
                    if (n_q[0]) begin
                        acc_d = prod[WIDTH-1:0];
                        n_d   = n_q - 1'b1;
                    end else begin
                        x_d = prod[WIDTH-1:0];
                        n_d = n_q >> 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        done  = done_q;
        out   = out_q;
        ovf   = ovf_q;
    end

endmodule
